gf163_sysmul_ctrl: RTL
======================

Name: gf163_sysmul_ctrl

Overview:
- Sequencer for the 8-bit-digit systolic GF(2^163) multiplier array.
- Accepts one operand pair through a valid/ready handshake and latches it.
- Streams operand digits and reduction-polynomial digits, MSB digit first, into the array head, and drives the array's ctr line.
- Waits the fixed array latency, then shifts result digits back into a 163-bit register and presents it through a valid/ready handshake.

Parameters:
- DIGITS, 8: digit width in bits.
- M, 163: field degree and operand width.
- NDIG, 21: digits per operand, ceil(M/DIGITS); padded width is 168 bits, top 5 bits zero.
- LAT, 42: cycles from the first FEED cycle to the first valid result digit; must satisfy LAT >= NDIG.
- POLY, x^163+x^7+x^6+x^3+1: reduction polynomial, padded to 168 bits.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start_valid  in  1  operand pair offered.
- start_ready  out  1  high only in IDLE.
- op_a  in  163  multiplicand; sampled only at accept.
- op_b  in  163  multiplier; sampled only at accept.
- arr_a  out  8  a digit to the array head.
- arr_b  out  8  b digit to the array head.
- arr_g  out  8  polynomial digit to the array head.
- arr_ctr  out  1  array control: 0 = load b, 1 = hold/accumulate.
- arr_t_in  in  8  result digit from the array tail.
- res  out  163  product, held stable while res_valid is high.
- res_valid  out  1  product available.
- res_ready  in  1  consumer accepts the product.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rstn low, any time, including mid-operation):
  - state = IDLE.
  - Counter, operand and result registers cleared.
  - All outputs 0 except start_ready = 1.
- States: IDLE, FEED, WAIT, COLLECT, DONE. A single 7-bit cycle counter c counts from 0 at the first FEED cycle.
- IDLE:
  - start_ready = 1.
  - On start_valid high at a clock edge: latch {5'b0, op_a} and {5'b0, op_b}, set c = 0, go to FEED.
  - start_valid while not IDLE is ignored and not stalled; the requester holds it.
- FEED, c = 0..NDIG-1:
  - arr_a, arr_b, arr_g = digit (NDIG-1-c) of the padded A, B and POLY, i.e. bits [167-8c : 160-8c].
  - arr_ctr = 0 at c = 0 and 1 for c = 1..NDIG-1.
  - At c = NDIG-1: go to WAIT, or straight to COLLECT if LAT == NDIG.
- WAIT, c = NDIG..LAT-1:
  - arr_a, arr_b, arr_g, arr_ctr = 0.
  - At c = LAT-1: go to COLLECT.
- COLLECT, c = LAT..LAT+NDIG-1:
  - Each cycle: shreg <= {shreg[159:0], arr_t_in}. The first captured digit is the MSB digit.
  - arr_* outputs = 0.
  - At the last capture: go to DONE.
- DONE:
  - res = shreg[162:0]; the 5 padding bits are discarded with no error flag.
  - res_valid = 1 from the cycle after the last capture, i.e. c = LAT+NDIG.
  - Hold until res_ready is high at a clock edge, then go to IDLE and drop res_valid.
  - res stays readable after the handshake until the next accepted start.
- Throughput: at most one product per LAT+NDIG+2 cycles; the next start can be accepted no earlier than the cycle after the result handshake.
- All arr_* outputs come from flops (no combinational path from inputs). arr_t_in is sampled only in COLLECT.
- Counter width covers LAT+NDIG-1 without wrap. Behaviour with LAT < NDIG is undefined; the bench asserts on it.

Test Plan:
- Reset mid-COLLECT: pulse rstn low at c = 50 → same cycle: res_valid = 0, busy = 0, start_ready = 1, arr_* = 0. Next start proceeds normally.
- op_a = 163'h1, op_b = all ones → arr_a = 0 for c = 0..19 and 8'h01 at c = 20; arr_b = 8'h07 at c = 0, 8'hFF for c = 1..20; arr_ctr pattern 0, then 1 x20, then 0.
- Polynomial stream check → arr_g = 8'h08 at c = 0, 8'h00 for c = 1..19, 8'hC9 at c = 20.
- arr_t_in held at 8'hA5 during COLLECT → res_valid rises exactly 63 cycles after the first FEED cycle; res = {3'b101, twenty repetitions of 8'hA5}.
- Hold res_ready low 10 cycles in DONE, start_valid held high throughout → res stable, start_ready = 0. On res_ready high: next cycle IDLE, and the new start is accepted in that cycle.
- Array stub instantiated with LAT = NDIG = 21 → WAIT skipped; COLLECT begins at c = 21; res_valid at c = 42.

Source files
------------

// File: rtl/gf163_sysmul_ctrl.sv
// rtl/gf163_sysmul_ctrl.sv - operand/polynomial digit sequencer and result collector for the GF(2^163) systolic multiplier
// Streams MSB-first digits into the array head, waits the array latency, shifts the product back in.
module gf163_sysmul_ctrl #(
  parameter int DIGITS = 8,
  parameter int M      = 163,
  parameter int NDIG   = (M + DIGITS - 1) / DIGITS,
  parameter int LAT    = 42
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [M-1:0]      op_a,
  input  logic [M-1:0]      op_b,
  output logic [DIGITS-1:0] arr_a,
  output logic [DIGITS-1:0] arr_b,
  output logic [DIGITS-1:0] arr_g,
  output logic              arr_ctr,
  input  logic [DIGITS-1:0] arr_t_in,
  output logic [M-1:0]      res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  localparam int W  = NDIG * DIGITS;
  localparam int CW = $clog2(LAT + NDIG) + 1;
  // x^163 + x^7 + x^6 + x^3 + 1, zero-padded to the full digit span
  localparam logic [W-1:0] POLY = (W'(1) << M) | W'(8'hC9);

  typedef enum logic [2:0] {IDLE, FEED, WAIT, COLLECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [M-1:0]      sh_q, sh_d;
  logic [DIGITS-1:0] arr_a_q, arr_a_d;
  logic [DIGITS-1:0] arr_b_q, arr_b_d;
  logic [DIGITS-1:0] arr_g_q, arr_g_d;
  logic              arr_ctr_q, arr_ctr_d;
  int                sh_amt;

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    a_d       = a_q;
    b_d       = b_q;
    sh_d      = sh_q;
    arr_a_d   = '0;
    arr_b_d   = '0;
    arr_g_d   = '0;
    arr_ctr_d = 1'b0;
    sh_amt    = 0;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = {{(W-M){1'b0}}, op_a};
          b_d     = {{(W-M){1'b0}}, op_b};
          c_d     = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        c_d = c_q + CW'(1);
        if (c_q == CW'(NDIG - 1)) state_d = (LAT == NDIG) ? COLLECT : WAIT;
      end
      WAIT: begin
        c_d = c_q + CW'(1);
        if (c_q == CW'(LAT - 1)) state_d = COLLECT;
      end
      COLLECT: begin
        c_d  = c_q + CW'(1);
        // Padding digits fall off the top after NDIG shifts, leaving exactly M result bits
        sh_d = {sh_q[M-DIGITS-1:0], arr_t_in};
        if (c_q == CW'(LAT + NDIG - 1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Array head digits are registered from the next-cycle counter so they line up with c
    if (state_d == FEED) begin
      sh_amt    = (NDIG - 1 - int'(c_d)) * DIGITS;
      arr_a_d   = DIGITS'(a_d >> sh_amt);
      arr_b_d   = DIGITS'(b_d >> sh_amt);
      arr_g_d   = DIGITS'(POLY >> sh_amt);
      arr_ctr_d = (c_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      c_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sh_q      <= '0;
      arr_a_q   <= '0;
      arr_b_q   <= '0;
      arr_g_q   <= '0;
      arr_ctr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sh_q      <= sh_d;
      arr_a_q   <= arr_a_d;
      arr_b_q   <= arr_b_d;
      arr_g_q   <= arr_g_d;
      arr_ctr_q <= arr_ctr_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == DONE);
  assign res         = sh_q;
  assign arr_a       = arr_a_q;
  assign arr_b       = arr_b_q;
  assign arr_g       = arr_g_q;
  assign arr_ctr     = arr_ctr_q;

endmodule
